ex_div_ctrl: RTL and testbench
==============================

# ex_div_ctrl

Multi-cycle integer divide sequencer for the EX stage of the LoongArch pipeline. It accepts DIV.W/DIV.WU/MOD.W/MOD.WU operands from EX, runs a 32-step restoring divide, and drives EX's ready-go so the stage stalls until the result is available. It holds the result under ME back-pressure and drops in-flight work on a pipeline flush.

## Interface
Parameters: none.

Ports (clock and reset first):
- clk  in  1  pipeline clock; single clock domain.
- resetn  in  1  synchronous, active-low reset, sampled on rising clk.
- div_req  in  1  EX holds a valid divide/modulo instruction; held high until accepted or cancelled.
- div_signed  in  1  1 selects DIV.W/MOD.W; 0 selects DIV.WU/MOD.WU.
- div_rem  in  1  1 returns the remainder (MOD); 0 returns the quotient (DIV).
- div_src1  in  32  dividend (rj_value).
- div_src2  in  32  divisor (rkd_value).
- div_accept  in  1  EX advances this cycle (EX ready-go && ME_Allow_in).
- div_cancel  in  1  pipeline flush; kills the current operation.
- div_ready_go  out  1  result valid; EX ORs it into its ready-go for divide instructions.
- div_result  out  32  selected quotient or remainder; valid only while div_ready_go=1.
- div_busy  out  1  state is not IDLE.

## Operation
States: IDLE, CALC, DONE. State encoding is a 2-bit register. The step counter is 5 bits.
- IDLE, div_req=1 and div_cancel=0:
  - latch |src1|, |src2|, quotient sign (src1[31]^src2[31] when signed), remainder sign (src1[31] when signed), and div_rem;
  - clear the partial remainder (33 bits) and the counter;
  - go to CALC.
- CALC, each cycle:
  - shift the next dividend bit into the partial remainder;
  - trial-subtract the divisor; restore if the result is negative;
  - shift the quotient bit in; increment the counter.
  - After step 31 (counter==31), go to DONE.
- DONE:
  - apply the sign fix-up (negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set);
  - assert div_ready_go; drive div_result from registers.
  - On div_accept=1, go to IDLE.
- Absolute value: for 0x80000000, unsigned interpretation 0x80000000 (no overflow trap).
- Divisor zero: quotient=0xFFFFFFFF and remainder=src1 (raw, no sign fix-up), for signed and unsigned. Same latency as a normal divide.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000 and remainder=0.
- Operands are latched at start. Changes on div_src1/div_src2/div_signed/div_rem after that are ignored.
- div_cancel has priority in every state: next state is IDLE and div_ready_go=0 next cycle. This holds even if div_req or div_accept is high in the same cycle.
- div_accept outside DONE is ignored.
- A new div_req is not sampled in the cycle DONE exits. One IDLE cycle is mandatory between operations.

## Timing
- Reset (resetn=0 at an edge): state=IDLE, counter=0, div_ready_go=0, div_busy=0, div_result=0. Reset mid-CALC or mid-DONE aborts with no residual output.
- Latency: div_req sampled in IDLE at edge E0, then CALC for edges E1..E32, then DONE after E32.
  - div_ready_go=1 is visible in the cycle after E32: 33 cycles after the request edge.
- div_ready_go and div_result are registered, with no combinational path from inputs.
- DONE holds div_ready_go=1 and a stable div_result indefinitely until div_accept or div_cancel.
- div_busy=1 from the cycle after E0 until the cycle after accept or cancel.

## Configuration
- DIV_EARLY_OUT_EN defined:
  - in IDLE, if |src2|==0 or |src1| < |src2| (unsigned), go directly to DONE;
  - quotient = 0 (or 0xFFFFFFFF for divisor zero); remainder = src1;
  - div_ready_go asserts in the cycle after E0.
  - Results are bit-identical to the full path.
- DIV_EARLY_OUT_EN undefined: every operation takes the full 33-cycle path.

## Test plan
- Unsigned 100 / 7, div_rem=0 then 1 -> div_result=0x0000000E, then 0x00000002. div_ready_go rises exactly 33 cycles after the request edge (1 cycle if DIV_EARLY_OUT_EN is defined and the early-out condition holds).
- Signed 0xFFFFFFF9 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Divide by zero, signed and unsigned, src1=0x12345678 -> quotient 0xFFFFFFFF, remainder 0x12345678.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0x00000000.
- div_cancel at CALC step 10 with div_req still high -> IDLE next cycle, div_ready_go stays 0. A fresh request afterwards completes correctly after a full 33 cycles.
- div_accept held low for 5 cycles in DONE, with operand inputs toggled -> div_ready_go=1 and div_result stable throughout. One cycle after div_accept=1: IDLE, div_busy=0.

Source files
------------

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: multi-cycle 32-bit integer divide sequencer for the EX stage.
// Runs a 32-step restoring divide on latched operand magnitudes, applies the
// sign fix-up on the final step and holds a registered result in DONE until
// EX advances (div_accept) or the pipeline flushes (div_cancel).
// Optional feature macro: DIV_EARLY_OUT_EN -- finishes in one cycle when the
// divisor is zero or |dividend| < |divisor|.
module ex_div_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_req,
  input  logic        div_signed,
  input  logic        div_rem,
  input  logic [31:0] div_src1,
  input  logic [31:0] div_src2,
  input  logic        div_accept,
  input  logic        div_cancel,
  output logic        div_ready_go,
  output logic [31:0] div_result,
  output logic        div_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Control state
  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_ready_go;
  logic        r_busy;
  logic [31:0] r_result;

  // Datapath state
  logic [31:0] r_quo;      // dividend magnitude, shifted out as quotient bits shift in
  logic [31:0] r_dvs;      // divisor magnitude
  logic [32:0] r_part;     // partial remainder
  logic        r_q_neg;
  logic        r_r_neg;
  logic        r_rem_sel;

  // Operand magnitudes; 0x80000000 maps onto itself, read as unsigned.
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic        w_div_zero;
  logic        w_start;

  assign w_abs1     = (div_signed && div_src1[31]) ? (~div_src1 + 32'd1) : div_src1;
  assign w_abs2     = (div_signed && div_src2[31]) ? (~div_src2 + 32'd1) : div_src2;
  assign w_div_zero = (div_src2 == 32'd0);
  assign w_start    = div_req && !div_cancel && (r_state == S_IDLE);

  // One restoring step: shift in the next dividend bit, trial-subtract.
  // The 34-bit trial result's top bit is the borrow (partial remainder < divisor).
  logic [32:0] w_shift;
  logic [33:0] w_trial;
  logic        w_qbit;
  logic [32:0] w_part_next;
  logic [31:0] w_quo_next;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;
  logic [31:0] w_final;

  assign w_shift     = {r_part[31:0], r_quo[31]};
  assign w_trial     = {r_part, r_quo[31]} - {2'b00, r_dvs};
  assign w_qbit      = ~w_trial[33];
  assign w_part_next = w_qbit ? w_trial[32:0] : w_shift;
  assign w_quo_next  = {r_quo[30:0], w_qbit};

  // Sign fix-up folded into the last step so the DONE result is a plain register.
  assign w_q_fix = r_q_neg ? (~w_quo_next + 32'd1) : w_quo_next;
  assign w_r_fix = r_r_neg ? (~w_part_next[31:0] + 32'd1) : w_part_next[31:0];
  assign w_final = r_rem_sel ? w_r_fix : w_q_fix;

`ifdef DIV_EARLY_OUT_EN
  // Trivial cases: quotient is 0 (or all-ones for a zero divisor), remainder is src1.
  logic        w_early;
  logic [31:0] w_early_result;

  assign w_early        = w_div_zero || (w_abs1 < w_abs2);
  assign w_early_result = div_rem ? div_src1 : {32{w_div_zero}};
`endif

  // Datapath: latch operands at start, then one restoring step per CALC cycle.
  // NOTE: datapath registers carry no reset; they are always loaded at start
  // and nothing observes them outside CALC, so resetting them only costs logic.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_quo     <= w_abs1;
      r_dvs     <= w_abs2;
      r_part    <= 33'd0;
      // A zero divisor keeps the all-ones quotient unsigned-looking; the
      // remainder fix-up then reproduces the raw src1 exactly.
      r_q_neg   <= div_signed && (div_src1[31] ^ div_src2[31]) && !w_div_zero;
      r_r_neg   <= div_signed && div_src1[31];
      r_rem_sel <= div_rem;
    end else if (r_state == S_CALC) begin
      r_quo  <= w_quo_next;
      r_part <= w_part_next;
    end
  end

  // Sequencer FSM with registered ready-go, result and busy; cancel wins everywhere.
  // NOTE: all state here uses non-blocking assignment so every branch reads
  // the pre-edge values, matching the hardware flops.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= 5'd0;
      r_ready_go <= 1'b0;
      r_busy     <= 1'b0;
      r_result   <= 32'd0;
    end else if (div_cancel) begin
      r_state    <= S_IDLE;
      r_cnt      <= 5'd0;
      r_ready_go <= 1'b0;
      r_busy     <= 1'b0;
      r_result   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (div_req) begin
            r_busy <= 1'b1;
            r_cnt  <= 5'd0;
`ifdef DIV_EARLY_OUT_EN
            if (w_early) begin
              r_state    <= S_DONE;
              r_ready_go <= 1'b1;
              r_result   <= w_early_result;
            end else begin
              r_state <= S_CALC;
            end
`else
            r_state <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state    <= S_DONE;
            r_ready_go <= 1'b1;
            r_result   <= w_final;
          end
        end
        S_DONE: begin
          if (div_accept) begin
            r_state    <= S_IDLE;
            r_ready_go <= 1'b0;
            r_busy     <= 1'b0;
            r_result   <= 32'd0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_ready_go <= 1'b0;
          r_busy     <= 1'b0;
          r_result   <= 32'd0;
        end
      endcase
    end
  end

  assign div_ready_go = r_ready_go;
  assign div_result   = r_result;
  assign div_busy     = r_busy;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: self-checking bench for ex_div_ctrl. Expected results come
// from plain integer arithmetic with the divide-by-zero and overflow rules.
module tb_ex_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_req;
  logic        div_signed;
  logic        div_rem;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_accept;
  logic        div_cancel;
  logic        div_ready_go;
  logic [31:0] div_result;
  logic        div_busy;

  int vectors     = 0;
  int miscompares = 0;

  ex_div_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .div_req      (div_req),
    .div_signed   (div_signed),
    .div_rem      (div_rem),
    .div_src1     (div_src1),
    .div_src2     (div_src2),
    .div_accept   (div_accept),
    .div_cancel   (div_cancel),
    .div_ready_go (div_ready_go),
    .div_result   (div_result),
    .div_busy     (div_busy)
  );

  always #5 clk = ~clk;

  // Reference result from the architectural rules.
  function automatic logic [31:0] model_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic sg, input logic rm);
    logic [31:0] q;
    logic [31:0] r;
    int sa;
    int sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return rm ? r : q;
  endfunction

  // Cycles from the request edge to the first cycle with ready-go visible.
  function automatic int model_latency(input logic [31:0] a, input logic [31:0] b,
                                       input logic sg);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] ma;
    logic [31:0] mb;
    ma = (sg && a[31]) ? -a : a;
    mb = (sg && b[31]) ? -b : b;
    if (b == 32'd0 || ma < mb) return 1;
`endif
    return 33;
  endfunction

  // Issue one operation, check latency and result, hold in DONE, then accept.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input logic rm, input int hold, input string name);
    logic [31:0] exp_res;
    int exp_lat;
    int cyc;
    exp_res = model_result(a, b, sg, rm);
    exp_lat = model_latency(a, b, sg);
    @(negedge clk);
    div_req = 1'b1; div_signed = sg; div_rem = rm; div_src1 = a; div_src2 = b;
    @(posedge clk);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (div_ready_go || cyc >= 60) break;
      // Operand changes and stray accepts during CALC must have no effect.
      div_src1   = $urandom;
      div_src2   = $urandom;
      div_signed = 1'($urandom_range(0, 1));
      div_rem    = 1'($urandom_range(0, 1));
      div_accept = 1'($urandom_range(0, 1));
    end
    vectors++;
    if (!div_ready_go) begin
      miscompares++;
      $display("FAIL %s timeout: ready_go=%0b after %0d cycles, required 1", name, div_ready_go, cyc);
      div_req = 1'b0; div_accept = 1'b0; div_cancel = 1'b1;
      @(negedge clk);
      div_cancel = 1'b0;
      return;
    end
    vectors++;
    if (cyc !== exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc, exp_lat);
    end
    vectors++;
    if (div_result !== exp_res) begin
      miscompares++;
      $display("FAIL %s result: got %08h, required %08h", name, div_result, exp_res);
    end
    for (int i = 0; i < hold; i++) begin
      div_accept = 1'b0;
      div_src1   = $urandom;
      div_src2   = $urandom;
      div_rem    = 1'($urandom_range(0, 1));
      @(negedge clk);
      vectors++;
      if (div_ready_go !== 1'b1 || div_result !== exp_res) begin
        miscompares++;
        $display("FAIL %s hold%0d: ready_go=%0b result=%08h, required 1 %08h",
                 name, i, div_ready_go, div_result, exp_res);
      end
    end
    div_accept = 1'b1;
    @(negedge clk);
    div_accept = 1'b0;
    div_req    = 1'b0;
    vectors++;
    if (div_busy !== 1'b0 || div_ready_go !== 1'b0) begin
      miscompares++;
      $display("FAIL %s release: busy=%0b ready_go=%0b, required 0 0", name, div_busy, div_ready_go);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    vectors++;
    if (div_ready_go !== 1'b0 || div_busy !== 1'b0 || div_result !== 32'd0) begin
      miscompares++;
      $display("FAIL reset: ready_go=%0b busy=%0b result=%08h, required 0 0 00000000",
               div_ready_go, div_busy, div_result);
    end
    // Reset in the middle of a calculation leaves nothing behind.
    div_req = 1'b1; div_signed = 1'b0; div_rem = 1'b0;
    div_src1 = 32'hFFFF_FFFF; div_src2 = 32'd3;
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn  = 1'b1;
    div_req = 1'b0;
    vectors++;
    if (div_ready_go !== 1'b0 || div_busy !== 1'b0 || div_result !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid_calc: ready_go=%0b busy=%0b result=%08h, required 0 0 00000000",
               div_ready_go, div_busy, div_result);
    end
  endtask

  task automatic test_directed();
    run_op(32'd100,        32'd7,          1'b0, 1'b0, 0, "udiv_100_7");
    run_op(32'd100,        32'd7,          1'b0, 1'b1, 0, "umod_100_7");
    run_op(32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0, 0, "sdiv_m7_2");
    run_op(32'hFFFF_FFF9,  32'd2,          1'b1, 1'b1, 0, "smod_m7_2");
    run_op(32'h1234_5678,  32'd0,          1'b1, 1'b0, 0, "sdiv_zero");
    run_op(32'h1234_5678,  32'd0,          1'b1, 1'b1, 0, "smod_zero");
    run_op(32'h1234_5678,  32'd0,          1'b0, 1'b0, 0, "udiv_zero");
    run_op(32'h1234_5678,  32'd0,          1'b0, 1'b1, 0, "umod_zero");
    run_op(32'h8765_4321,  32'd0,          1'b1, 1'b1, 0, "smod_zero_neg");
    run_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, 0, "sdiv_ovf");
    run_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b1, 0, "smod_ovf");
    run_op(32'h8000_0000,  32'd3,          1'b1, 1'b1, 0, "smod_min_3");
    run_op(32'd5,          32'hFFFF_FFFE,  1'b0, 1'b0, 0, "udiv_small");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 30);
        default: a = $urandom;
      endcase
      run_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_cancel();
    int cyc;
    // Cancel mid-CALC with the request still asserted.
    @(negedge clk);
    div_req = 1'b1; div_signed = 1'b0; div_rem = 1'b0;
    div_src1 = 32'hFFFF_0000; div_src2 = 32'd3;
    @(posedge clk);
    repeat (10) @(negedge clk);
    div_cancel = 1'b1;
    @(negedge clk);
    div_cancel = 1'b0;
    div_req    = 1'b0;
    vectors++;
    if (div_busy !== 1'b0 || div_ready_go !== 1'b0) begin
      miscompares++;
      $display("FAIL cancel_calc: busy=%0b ready_go=%0b, required 0 0", div_busy, div_ready_go);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (div_ready_go !== 1'b0) begin
      miscompares++;
      $display("FAIL cancel_quiet: ready_go=%0b, required 0", div_ready_go);
    end
    run_op(32'hFFFF_0000, 32'd3, 1'b0, 1'b0, 0, "after_cancel");

    // Cancel in DONE beats a simultaneous accept and request.
    @(negedge clk);
    div_req = 1'b1; div_signed = 1'b1; div_rem = 1'b0;
    div_src1 = 32'd1000; div_src2 = 32'd9;
    cyc = 0;
    while (!div_ready_go && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    div_cancel = 1'b1;
    div_accept = 1'b1;
    @(negedge clk);
    div_cancel = 1'b0;
    div_accept = 1'b0;
    div_req    = 1'b0;
    vectors++;
    if (cyc >= 60 || div_busy !== 1'b0 || div_ready_go !== 1'b0) begin
      miscompares++;
      $display("FAIL cancel_done: cycles=%0d busy=%0b ready_go=%0b, required <60 0 0",
               cyc, div_busy, div_ready_go);
    end
  endtask

  task automatic test_hold();
    run_op(32'd100,       32'd7, 1'b0, 1'b0, 5, "hold_udiv");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 5, "hold_smod");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++)
      run_op($urandom, $urandom_range(1, 1000), 1'($urandom_range(0, 1)), 1'(n % 2), 0, "b2b");
  endtask

  initial begin
    resetn = 1'b0; div_req = 1'b0; div_signed = 1'b0; div_rem = 1'b0;
    div_src1 = 32'd0; div_src2 = 32'd0; div_accept = 1'b0; div_cancel = 1'b0;
    test_reset();
    test_directed();
    test_cancel();
    test_hold();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
